// File: rtl/wave_osc_pkg.sv
// Shared types and helpers for the wave_osc oscillator.
package wave_osc_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_PULSE  = 2'd3
  } wave_mode_e;

  localparam int WAVE_MODE_W = 2;

  // Largest positive two's complement value representable in width bits.
  function automatic int max_val(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

endpackage

// File: rtl/wave_osc_if.sv
// Sample stream and control bundle between wave_osc and its consumer.
// The sync_i signal exists only when WAVE_OSC_SYNC_EN is defined.
interface wave_osc_if
  import wave_osc_pkg::*;
#(
  parameter int width_p       = 12,
  parameter int phase_width_p = 16
) ();

  logic                      ready_i;
  logic [phase_width_p-1:0]  freq_i;
  wave_mode_e                mode_i;
  logic [width_p-1:0]        duty_i;
  logic signed [width_p-1:0] data_o;
  logic                      valid_o;
`ifdef WAVE_OSC_SYNC_EN
  logic                      sync_i;

  modport master (input ready_i, freq_i, mode_i, duty_i, sync_i, output data_o, valid_o);
  modport slave  (output ready_i, freq_i, mode_i, duty_i, sync_i, input data_o, valid_o);
`else
  modport master (input ready_i, freq_i, mode_i, duty_i, output data_o, valid_o);
  modport slave  (output ready_i, freq_i, mode_i, duty_i, input data_o, valid_o);
`endif

endinterface

// File: rtl/wave_osc_shaper.sv
// Combinational waveform mapping from the top phase bits, mode and duty to a signed sample.
module wave_shaper
  import wave_osc_pkg::*;
#(
  parameter int width_p = 12
) (
  input  logic [width_p-1:0]        r_i,
  input  wave_mode_e                mode_i,
  input  logic [width_p-1:0]        duty_i,
  output logic signed [width_p-1:0] sample_o
);

  localparam logic signed [width_p-1:0] MaxVal = width_p'(max_val(width_p));

  logic [width_p-2:0] tri_t;

  always_comb begin
    // Fold the second half of the cycle back down so the ramp goes up then down.
    tri_t    = r_i[width_p-1] ? ~r_i[width_p-2:0] : r_i[width_p-2:0];
    sample_o = MaxVal;
    case (mode_i)
      MODE_SQUARE: sample_o = r_i[width_p-1] ? -MaxVal : MaxVal;
      MODE_SAW:    sample_o = {~r_i[width_p-1], r_i[width_p-2:0]};
      MODE_TRI:    sample_o = {~tri_t[width_p-2], tri_t[width_p-3:0], 1'b0};
      MODE_PULSE:  sample_o = (r_i < duty_i) ? MaxVal : -MaxVal;
      default:     sample_o = MaxVal;
    endcase
  end

endmodule

// File: rtl/wave_osc.sv
// Runtime-tunable multi-mode oscillator with a valid/ready sample output.
// Optional hard sync input enabled by defining WAVE_OSC_SYNC_EN.
module wave_osc
  import wave_osc_pkg::*;
#(
  parameter int width_p       = 12,
  parameter int phase_width_p = 16
) (
  input logic        clk_i,
  input logic        reset_i,
  wave_osc_if.master bus
);

  logic [phase_width_p-1:0]  phase_q, phase_d;
  logic [phase_width_p-1:0]  phase_sum, shape_phase;
  logic signed [width_p-1:0] data_q, data_d;
  logic signed [width_p-1:0] shape_sample;
  logic                      valid_q, valid_d;
  logic                      accept, restart;

  assign accept = valid_q & bus.ready_i;
`ifdef WAVE_OSC_SYNC_EN
  assign restart = ~valid_q | bus.sync_i;
`else
  assign restart = ~valid_q;
`endif

  // Prime and sync both emit the phase-0 sample, so one shaper serves every path.
  assign phase_sum   = phase_q + bus.freq_i;
  assign shape_phase = restart ? '0 : phase_sum;

  wave_shaper #(.width_p(width_p)) u_shaper (
    .r_i      (shape_phase[phase_width_p-1 -: width_p]),
    .mode_i   (bus.mode_i),
    .duty_i   (bus.duty_i),
    .sample_o (shape_sample)
  );

  always_comb begin
    phase_d = phase_q;
    data_d  = data_q;
    valid_d = 1'b1;
    if (restart) begin
      phase_d = '0;
      data_d  = shape_sample;
    end else if (accept) begin
      phase_d = phase_sum;
      data_d  = shape_sample;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      phase_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_wave_osc.sv
// Scoreboard bench for wave_osc: the driver queues expected samples, a monitor pops them
// whenever the oscillator produces a new one.
module tb_wave_osc;
  import wave_osc_pkg::*;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk_i = ~clk_i;

  wave_osc_if #(.width_p(12), .phase_width_p(16)) bus ();

  wave_osc #(.width_p(12), .phase_width_p(16)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  logic signed [11:0] exp_q[$];

  int sq_exp[8]  = '{2047, -2047, -2047, 2047, 2047, -2047, -2047, 2047};
  int tri_exp[8] = '{0, 2046, -2, -2048, 0, 2046, -2, -2048};

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic acc(input int e);
    bus.ready_i = 1'b1;
    exp_q.push_back(12'(e));
    cyc();
  endtask

  task automatic do_reset(input wave_mode_e m, input logic [11:0] d, input int prime_exp);
    reset_i     = 1'b0;
    bus.ready_i = 1'b0;
    repeat (3) cyc();
    check("reset_data", int'(bus.data_o), 0);
    check("reset_valid", int'(bus.valid_o), 0);
    bus.mode_i = m;
    bus.duty_i = d;
    reset_i    = 1'b1;
    exp_q.push_back(12'(prime_exp));
    cyc();
    check("prime_valid", int'(bus.valid_o), 1);
  endtask

  // Monitor: decides before each edge whether a new sample will appear, then checks it.
  initial begin : monitor
    logic fire;
    logic signed [11:0] e;
    forever begin
      @(negedge clk_i);
`ifdef WAVE_OSC_SYNC_EN
      fire = reset_i && (!bus.valid_o || bus.ready_i || bus.sync_i);
`else
      fire = reset_i && (!bus.valid_o || bus.ready_i);
`endif
      @(posedge clk_i);
      #1;
      if (fire) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sample_unexpected: got %0d, want no sample", int'(bus.data_o));
        end else begin
          e = exp_q.pop_front();
          check("sample", int'(bus.data_o), int'(e));
          check("sample_valid", int'(bus.valid_o), 1);
        end
      end
    end
  end

  initial begin : driver
    bus.ready_i = 1'b0;
    bus.freq_i  = '0;
    bus.mode_i  = MODE_SQUARE;
    bus.duty_i  = '0;
`ifdef WAVE_OSC_SYNC_EN
    bus.sync_i  = 1'b0;
`endif

    // Square, period 4
    do_reset(MODE_SQUARE, 12'h000, 2047);
    bus.freq_i = 16'h4000;
    for (int i = 0; i < 8; i++) acc(sq_exp[i]);

    // Saw with wrap back to -2048
    do_reset(MODE_SAW, 12'h000, -2048);
    bus.freq_i = 16'h1000;
    for (int k = 1; k <= 17; k++) acc(-2048 + 256 * (k % 16));

    // Triangle
    do_reset(MODE_TRI, 12'h000, -2048);
    bus.freq_i = 16'h4000;
    for (int i = 0; i < 8; i++) acc(tri_exp[i]);

    // Pulse, then zero duty
    do_reset(MODE_PULSE, 12'h400, 2047);
    bus.freq_i = 16'h1000;
    for (int k = 1; k <= 16; k++) acc(((k % 16) < 4) ? 2047 : -2047);
    bus.duty_i = 12'h000;
    for (int k = 0; k < 6; k++) acc(-2047);

    // Backpressure with control changes while stalled
    do_reset(MODE_SAW, 12'h000, -2048);
    bus.freq_i = 16'h1000;
    acc(-1792);
    acc(-1536);
    acc(-1280);
    bus.ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mode_i = (i % 2 == 1) ? MODE_TRI : MODE_PULSE;
      bus.freq_i = 16'h0700 + 16'(i);
      cyc();
      check("stall_data", int'(bus.data_o), -1280);
      check("stall_valid", int'(bus.valid_o), 1);
    end
    bus.mode_i = MODE_TRI;
    bus.freq_i = 16'h2000;
    acc(512);
    acc(1536);

    // Reset while ready is high
    bus.ready_i = 1'b1;
    reset_i     = 1'b0;
    cyc();
    check("midreset_data", int'(bus.data_o), 0);
    check("midreset_valid", int'(bus.valid_o), 0);

    // Zero tuning word holds a constant sample
    do_reset(MODE_SAW, 12'h000, -2048);
    bus.freq_i = 16'h0000;
    for (int k = 0; k < 3; k++) acc(-2048);

`ifdef WAVE_OSC_SYNC_EN
    // Hard sync with and without a simultaneous accept
    do_reset(MODE_SAW, 12'h000, -2048);
    bus.freq_i = 16'h1000;
    acc(-1792);
    acc(-1536);
    bus.sync_i = 1'b1;
    acc(-2048);
    bus.sync_i = 1'b0;
    acc(-1792);
    acc(-1536);
    bus.ready_i = 1'b0;
    bus.sync_i  = 1'b1;
    exp_q.push_back(12'(-2048));
    cyc();
    bus.sync_i = 1'b0;
    acc(-1792);
`endif

    bus.ready_i = 1'b0;
    cyc();
    cyc();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
